pepelatz_stack: RTL and testbench
=================================

PEPELATZ_STACK -- requirements
Module: pepelatz_stack

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH  16  data word width in bits.
  DEPTH  64  maximum stack entries including cached TOS and NOS; legal range 4..1024.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning (clock and reset first).
  clk  input  1  single clock; all state changes on the rising edge.
  rst  input  1  synchronous, active-high reset.
  op_valid  input  1  an operation is presented.
  op  input  3  opcode, encoded per REQ-006.
  op_ready  output  1  the stack accepts an operation this cycle.
  push_data  input  WIDTH  operand for PUSH and REPLACE.
  tos  output  WIDTH  top of stack.
  nos  output  WIDTH  next on stack.
  count  output  $clog2(DEPTH+1)  number of valid entries.
  empty  output  1  count==0.
  full  output  1  count==DEPTH.
  err_overflow  output  1  overflow error flag.
  err_underflow  output  1  underflow error flag.
  err_clear  input  1  clears the sticky error flags (REQ-017).
REQ-003 The design SHALL use one clock domain: clk, with rst synchronous and active-high.

Function
REQ-004 An operation SHALL be accepted on any rising edge where op_valid && op_ready.
REQ-005 TOS and NOS SHALL be held in registers; entries 3..DEPTH SHALL be held in a (DEPTH-2)xWIDTH array with synchronous read.
REQ-006 Opcodes, with count change:
  000 NOP (0).
  001 PUSH (+1): NOS<=TOS, TOS<=push_data; old NOS spills to the array.
  010 POP (-1): TOS<=NOS.
  011 DUP (+1): NOS<=TOS, old NOS spills.
  100 SWAP (0): exchange TOS and NOS.
  101 OVER (+1): TOS<=NOS, NOS<=TOS, old NOS spills.
  110 REPLACE (0): TOS<=push_data.
  111 reserved; SHALL behave as NOP.
REQ-007 The FSM SHALL have two states, IDLE and REFILL; op_ready SHALL be 1 in IDLE and 0 in REFILL.
REQ-008 A POP accepted with count>2 SHALL move the FSM to REFILL for exactly one cycle, during which NOS<=array top; the FSM then returns to IDLE.
  - tos and count SHALL update at the accepting edge.
  - nos SHALL be valid one edge later.
REQ-009 All other accepted operations SHALL complete at the accepting edge with no stall.
REQ-010 nos SHALL read 0 whenever count<2; tos SHALL read 0 whenever count==0.
REQ-011 Overflow: PUSH/DUP/OVER accepted while full SHALL leave all stack state unchanged and set err_overflow.
REQ-012 Underflow: POP/REPLACE with count==0, or SWAP/OVER with count<2, SHALL leave all stack state unchanged and set err_underflow.
REQ-013 The array pointer SHALL never wrap; the boundary checks in REQ-011 and REQ-012 prevent wrap-around.
REQ-014 op_valid asserted during REFILL SHALL NOT be accepted and SHALL have no side effect.
REQ-015 If an error condition and err_clear occur in the same cycle, the error flag SHALL be set (the set wins).

Reset
REQ-016 When rst is sampled high, the block SHALL enter IDLE with count=0, tos=0, nos=0, empty=1, full=0, err_overflow=0, err_underflow=0, op_ready=1.
  - Reset SHALL take effect even during REFILL.
  - Array contents SHALL NOT be cleared.

Configuration
REQ-017 Macro PEPELATZ_STACK_STICKY_ERR_EN SHALL control error-flag behaviour.
  - Defined: err_overflow and err_underflow SHALL be sticky until err_clear is sampled high.
  - Undefined: each flag SHALL be a one-cycle pulse in the cycle after the offending edge, and err_clear SHALL be ignored.

Verification
REQ-018 Reset, then PUSH 0x1111, PUSH 0x2222, PUSH 0x3333 -> tos=0x3333, nos=0x2222, count=3, no stalls.
REQ-019 From REQ-018, POP -> tos=0x2222 next edge, op_ready=0 for one cycle, then nos=0x1111, count=2; op_valid held during the stall is ignored.
REQ-020 DEPTH=4: push 4 values, then PUSH 0xAAAA -> count stays 4, tos unchanged, err_overflow=1. Sticky build: flag held until err_clear. Non-sticky build: flag high for one cycle.
REQ-021 Empty stack: POP, then SWAP with count=1 -> state unchanged, err_underflow=1; err_clear coincident with the SWAP error leaves the flag set.
REQ-022 count=2 (tos=0x0002, nos=0x0001): SWAP -> tos=0x0001, nos=0x0002; OVER -> tos=0x0002, nos=0x0001, count=3; DUP, REPLACE 0x00FF -> tos=0x00FF, nos=0x0002, count=4.
REQ-023 Assert rst during REFILL -> next cycle count=0, op_ready=1, all flags 0.

Source files
------------

// File: rtl/pepelatz_stack.sv
// pepelatz_stack: LIFO stack with TOS/NOS held in registers and deeper
// entries in a synchronously read array; a POP that needs a refill stalls
// for one cycle.
// Optional build macro: PEPELATZ_STACK_STICKY_ERR_EN. When it is defined,
// the error flags stay set until err_clear. When it is not defined, each
// flag is a one-cycle pulse and err_clear is ignored.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   op_valid/op       - operation request and 3-bit opcode
//   op_ready          - high when idle, low while NOS is being refilled
//   push_data         - operand for PUSH and REPLACE
//   tos, nos          - top and next-on-stack (masked to 0 when absent)
//   count/empty/full  - occupancy
//   err_overflow      - error flag for a PUSH/DUP/OVER into a full stack
//   err_underflow     - error flag for an op on too few entries
//   err_clear         - clears the sticky error flags
module pepelatz_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       op_valid,
   input  logic [2:0]                 op,
   output logic                       op_ready,
   input  logic [WIDTH-1:0]           push_data,
   output logic [WIDTH-1:0]           tos,
   output logic [WIDTH-1:0]           nos,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       err_overflow,
   output logic                       err_underflow,
   input  logic                       err_clear
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH-2);

   localparam logic [2:0] OP_PUSH    = 3'b001;
   localparam logic [2:0] OP_POP     = 3'b010;
   localparam logic [2:0] OP_DUP     = 3'b011;
   localparam logic [2:0] OP_SWAP    = 3'b100;
   localparam logic [2:0] OP_OVER    = 3'b101;
   localparam logic [2:0] OP_REPLACE = 3'b110;

   typedef enum logic {IDLE, REFILL} state_t;

   state_t           state;
   logic [WIDTH-1:0] tos_q;
   logic [WIDTH-1:0] nos_q;
   logic [WIDTH-1:0] rd_q;
   logic [CW-1:0]    cnt_q;
   logic             err_ov_q;
   logic             err_un_q;

   logic [WIDTH-1:0] mem [DEPTH-2];

   logic             acc;
   logic             is_empty;
   logic             is_full;
   logic             lt2;
   logic [WIDTH-1:0] tos_v;
   logic [WIDTH-1:0] nos_v;
   logic [WIDTH-1:0] tos_n;
   logic [WIDTH-1:0] nos_n;
   logic [CW-1:0]    cnt_n;
   logic             spill;
   logic             refill;
   logic             ov;
   logic             un;
   logic [AW-1:0]    wr_addr;
   logic [AW-1:0]    rd_addr;

   assign acc      = op_valid && (state == IDLE);
   assign is_empty = (cnt_q == '0);
   assign is_full  = (cnt_q == CW'(DEPTH));
   assign lt2      = (cnt_q < CW'(2));
   assign tos_v    = is_empty ? '0 : tos_q;
   assign nos_v    = lt2 ? '0 : nos_q;

   // Array slot k holds stack entry k+3 counted from the bottom-most
   // array entry; the next free slot is count-2, the top is count-3.
   assign wr_addr = AW'(cnt_q - CW'(2));
   assign rd_addr = AW'(cnt_q - CW'(3));

   always_comb begin
      tos_n  = tos_q;
      nos_n  = nos_q;
      cnt_n  = cnt_q;
      spill  = 1'b0;
      refill = 1'b0;
      ov     = 1'b0;
      un     = 1'b0;
      if (acc) begin
         unique case (op)
            OP_PUSH: begin
               if (is_full) begin
                  ov = 1'b1;
               end else begin
                  tos_n = push_data;
                  nos_n = tos_v;
                  cnt_n = cnt_q + CW'(1);
                  spill = !lt2;
               end
            end
            OP_POP: begin
               if (is_empty) begin
                  un = 1'b1;
               end else begin
                  tos_n  = nos_v;
                  nos_n  = '0;
                  cnt_n  = cnt_q - CW'(1);
                  refill = (cnt_q > CW'(2));
               end
            end
            OP_DUP: begin
               if (is_full) begin
                  ov = 1'b1;
               end else begin
                  tos_n = tos_v;
                  nos_n = tos_v;
                  cnt_n = cnt_q + CW'(1);
                  spill = !lt2;
               end
            end
            OP_SWAP: begin
               if (lt2) begin
                  un = 1'b1;
               end else begin
                  tos_n = nos_q;
                  nos_n = tos_q;
               end
            end
            OP_OVER: begin
               if (is_full) begin
                  ov = 1'b1;
               end else if (lt2) begin
                  un = 1'b1;
               end else begin
                  tos_n = nos_q;
                  nos_n = tos_q;
                  cnt_n = cnt_q + CW'(1);
                  spill = 1'b1;
               end
            end
            OP_REPLACE: begin
               if (is_empty) begin
                  un = 1'b1;
               end else begin
                  tos_n = push_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Array has no reset; only the pointer (count) is cleared.
   always_ff @(posedge clk) begin
      if (spill) begin
         mem[wr_addr] <= nos_q;
      end
      rd_q <= mem[rd_addr];
   end

`ifndef PEPELATZ_STACK_STICKY_ERR_EN
   logic unused_err_clear;
   assign unused_err_clear = err_clear;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tos_q    <= '0;
         nos_q    <= '0;
         cnt_q    <= '0;
         err_ov_q <= 1'b0;
         err_un_q <= 1'b0;
      end else begin
         tos_q <= tos_n;
         cnt_q <= cnt_n;
         unique case (state)
            IDLE: begin
               nos_q <= nos_n;
               if (refill) begin
                  state <= REFILL;
               end
            end
            REFILL: begin
               // rd_q was loaded with the array top at the POP edge.
               nos_q <= rd_q;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
`ifdef PEPELATZ_STACK_STICKY_ERR_EN
         err_ov_q <= ov | (err_ov_q & ~err_clear);
         err_un_q <= un | (err_un_q & ~err_clear);
`else
         err_ov_q <= ov;
         err_un_q <= un;
`endif
      end
   end

   assign op_ready      = (state == IDLE);
   assign tos           = tos_v;
   assign nos           = nos_v;
   assign count         = cnt_q;
   assign empty         = is_empty;
   assign full          = is_full;
   assign err_overflow  = err_ov_q;
   assign err_underflow = err_un_q;

endmodule

// File: tb/tb_pepelatz_stack.sv
// tb_pepelatz_stack: queue-based reference model plus directed vectors
// for pepelatz_stack with WIDTH=16, DEPTH=4.
module tb_pepelatz_stack;

   localparam int W  = 16;
   localparam int D  = 4;
   localparam int CW = $clog2(D+1);

   localparam logic [2:0] NOP  = 3'b000;
   localparam logic [2:0] PUSH = 3'b001;
   localparam logic [2:0] POP  = 3'b010;
   localparam logic [2:0] DUP  = 3'b011;
   localparam logic [2:0] SWAP = 3'b100;
   localparam logic [2:0] OVER = 3'b101;
   localparam logic [2:0] REPL = 3'b110;
   localparam logic [2:0] RSVD = 3'b111;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          op_valid = 1'b0;
   logic [2:0]    op = 3'b000;
   logic          op_ready;
   logic [W-1:0]  push_data = '0;
   logic [W-1:0]  tos;
   logic [W-1:0]  nos;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;
   logic          err_overflow;
   logic          err_underflow;
   logic          err_clear = 1'b0;

   int n_pass = 0;
   int n_chk  = 0;

   pepelatz_stack #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk),
      .rst(rst),
      .op_valid(op_valid),
      .op(op),
      .op_ready(op_ready),
      .push_data(push_data),
      .tos(tos),
      .nos(nos),
      .count(count),
      .empty(empty),
      .full(full),
      .err_overflow(err_overflow),
      .err_underflow(err_underflow),
      .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end else begin
         n_pass = n_pass + 1;
      end
   endtask

   // Reference model: the stack is a queue, q[$] is the top.
   logic [W-1:0] q[$];
   logic         m_stall = 1'b0;
   logic         m_ov = 1'b0;
   logic         m_un = 1'b0;
   logic         live = 1'b0;
   logic         ev_ov;
   logic         ev_un;
   logic         nxt_stall;
   logic [W-1:0] tmp;
   int           n;

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_stall = 1'b0;
         m_ov = 1'b0;
         m_un = 1'b0;
         live = 1'b1;
      end else begin
         ev_ov = 1'b0;
         ev_un = 1'b0;
         nxt_stall = 1'b0;
         n = q.size();
         if (op_valid && !m_stall) begin
            case (op)
               PUSH: if (n == D) ev_ov = 1'b1;
                     else q.push_back(push_data);
               POP: begin
                  if (n == 0) ev_un = 1'b1;
                  else begin
                     tmp = q.pop_back();
                     nxt_stall = (n > 2);
                  end
               end
               DUP: begin
                  if (n == D) ev_ov = 1'b1;
                  else if (n == 0) q.push_back('0);
                  else q.push_back(q[n-1]);
               end
               SWAP: begin
                  if (n < 2) ev_un = 1'b1;
                  else begin
                     tmp = q[n-1];
                     q[n-1] = q[n-2];
                     q[n-2] = tmp;
                  end
               end
               OVER: begin
                  if (n == D) ev_ov = 1'b1;
                  else if (n < 2) ev_un = 1'b1;
                  else q.push_back(q[n-2]);
               end
               REPL: if (n == 0) ev_un = 1'b1;
                     else q[n-1] = push_data;
               default: ;
            endcase
         end
         m_stall = nxt_stall;
`ifdef PEPELATZ_STACK_STICKY_ERR_EN
         m_ov = ev_ov | (m_ov & ~err_clear);
         m_un = ev_un | (m_un & ~err_clear);
`else
         m_ov = ev_ov;
         m_un = ev_un;
`endif
      end
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      if (live) begin
         n = q.size();
         chk("op_ready", op_ready, !m_stall);
         chk("count", count, n);
         chk("empty", empty, n == 0);
         chk("full", full, n == D);
         chk("tos", tos, (n > 0) ? q[n-1] : '0);
         if (!m_stall)
            chk("nos", nos, (n > 1) ? q[n-2] : '0);
         chk("err_overflow", err_overflow, m_ov);
         chk("err_underflow", err_underflow, m_un);
      end
   end

   task automatic do_op(input logic v, input logic [2:0] o,
                        input logic [W-1:0] d, input logic c);
      op_valid  = v;
      op        = o;
      push_data = d;
      err_clear = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      do_op(1'b0, NOP, '0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_count", count, 0);
      chk("rst_ready", op_ready, 1);
      chk("rst_empty", empty, 1);
      chk("rst_tos", tos, 0);
      chk("rst_nos", nos, 0);

      // Three pushes, no stalls
      do_op(1'b1, PUSH, 16'h1111, 1'b0);
      chk("p1_ready", op_ready, 1);
      do_op(1'b1, PUSH, 16'h2222, 1'b0);
      do_op(1'b1, PUSH, 16'h3333, 1'b0);
      chk("p3_tos", tos, 16'h3333);
      chk("p3_nos", nos, 16'h2222);
      chk("p3_count", count, 3);
      chk("p3_ready", op_ready, 1);

      // POP with refill; a request held during the stall is ignored
      do_op(1'b1, POP, '0, 1'b0);
      chk("pop_tos", tos, 16'h2222);
      chk("pop_count", count, 2);
      chk("pop_stall", op_ready, 0);
      do_op(1'b1, PUSH, 16'hDEAD, 1'b0);
      chk("rf_ready", op_ready, 1);
      chk("rf_nos", nos, 16'h1111);
      chk("rf_count", count, 2);
      chk("rf_tos", tos, 16'h2222);
      do_op(1'b0, NOP, '0, 1'b0);

      // Overflow on a full stack
      do_reset();
      for (int i = 1; i <= 4; i++)
         do_op(1'b1, PUSH, W'(16'h0A00 + i), 1'b0);
      chk("full_flag", full, 1);
      do_op(1'b1, PUSH, 16'hAAAA, 1'b0);
      chk("ovf_count", count, 4);
      chk("ovf_tos", tos, 16'h0A04);
      chk("ovf_flag", err_overflow, 1);
      do_op(1'b1, DUP, '0, 1'b0);
      do_op(1'b1, OVER, '0, 1'b0);
      do_op(1'b0, NOP, '0, 1'b0);
`ifdef PEPELATZ_STACK_STICKY_ERR_EN
      chk("ovf_hold", err_overflow, 1);
`else
      chk("ovf_pulse", err_overflow, 0);
`endif
      do_op(1'b0, NOP, '0, 1'b1);
      chk("ovf_clr", err_overflow, 0);
      // Drain through two refills
      for (int i = 0; i < 5; i++) begin
         do_op(1'b1, POP, '0, 1'b0);
         if (!op_ready) do_op(1'b0, NOP, '0, 1'b0);
      end
      chk("drain_empty", empty, 1);

      // Underflow cases
      do_reset();
      do_op(1'b1, POP, '0, 1'b0);
      chk("unf_pop", err_underflow, 1);
      chk("unf_count", count, 0);
      do_op(1'b1, REPL, 16'h7777, 1'b0);
      do_op(1'b1, PUSH, 16'h0005, 1'b0);
      do_op(1'b1, SWAP, '0, 1'b1);
      chk("unf_swap", err_underflow, 1);
      chk("unf_tos", tos, 16'h0005);
      chk("unf_cnt1", count, 1);
      do_op(1'b1, OVER, '0, 1'b0);
      do_op(1'b1, RSVD, 16'h1234, 1'b0);
      do_op(1'b1, NOP, '0, 1'b1);

      // SWAP / OVER / DUP / REPLACE
      do_reset();
      do_op(1'b1, DUP, '0, 1'b0);
      chk("dup0_count", count, 1);
      do_op(1'b1, POP, '0, 1'b0);
      do_op(1'b1, PUSH, 16'h0001, 1'b0);
      do_op(1'b1, PUSH, 16'h0002, 1'b0);
      do_op(1'b1, SWAP, '0, 1'b0);
      chk("swap_tos", tos, 16'h0001);
      chk("swap_nos", nos, 16'h0002);
      do_op(1'b1, OVER, '0, 1'b0);
      chk("over_tos", tos, 16'h0002);
      chk("over_nos", nos, 16'h0001);
      chk("over_count", count, 3);
      do_op(1'b1, DUP, '0, 1'b0);
      do_op(1'b1, REPL, 16'h00FF, 1'b0);
      chk("repl_tos", tos, 16'h00FF);
      chk("repl_nos", nos, 16'h0002);
      chk("repl_count", count, 4);
      do_op(1'b1, POP, '0, 1'b0);
      do_op(1'b0, NOP, '0, 1'b0);
      chk("refill_nos", nos, 16'h0001);

      // Reset during REFILL
      do_op(1'b1, POP, '0, 1'b0);
      chk("pre_rst_stall", op_ready, 0);
      rst = 1'b1;
      do_op(1'b0, NOP, '0, 1'b0);
      rst = 1'b0;
      chk("rr_count", count, 0);
      chk("rr_ready", op_ready, 1);
      chk("rr_ovf", err_overflow, 0);
      chk("rr_unf", err_underflow, 0);
      do_op(1'b0, NOP, '0, 1'b0);
      do_op(1'b0, NOP, '0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
